riscv_dbg_ctrl: RTL and testbench
=================================

# riscv_dbg_ctrl

Debug-port master sitting directly upstream of the RISC-V debug unit: it converts serialized host debug commands (from the JTAG/TAP or SoC debug bus adapter) into the debug unit's strobe/ack port protocol. It owns the CPU halt state (`dbg_stall`) and enters it automatically when the debug unit reports a breakpoint. It rejects GPR/CSR accesses while the CPU runs and bounds every access with an optional ack timeout.

## Interface
- `XLEN`, 32, data width
- `DBG_ADDR_SIZE`, 16, debug address width; bank field = `dbg_addr[DBG_ADDR_SIZE-1:12]`, internal bank = 0
- `TIMEOUT`, 255, max cycles waiting for `dbg_ack` (1..65535)
- `clk`  in  1  clock
- `rstn`  in  1  reset: asynchronous, active-low
- `host_req`  in  1  command valid
- `host_gnt`  out  1  command accepted (ready)
- `host_cmd`  in  2  00 read, 01 write, 10 halt, 11 resume
- `host_addr`  in  DBG_ADDR_SIZE  access address
- `host_wdata`  in  XLEN  write data
- `host_rsp_vld`  out  1  response valid
- `host_rsp_rdy`  in  1  response accepted
- `host_rsp_data`  out  XLEN  read data (0 for non-read or error)
- `host_rsp_err`  out  1  1 = rejected or timed out
- `host_halted`  out  1  CPU halted (mirror of `dbg_stall`)
- `host_bp_halt`  out  1  sticky: last halt caused by breakpoint
- `dbg_stall`  out  1  CPU stall request to debug unit
- `dbg_strb`  out  1  access strobe
- `dbg_we`  out  1  write enable
- `dbg_addr`  out  DBG_ADDR_SIZE  access address
- `dbg_dati`  out  XLEN  write data to debug unit
- `dbg_dato`  in  XLEN  read data from debug unit
- `dbg_ack`  in  1  access acknowledge, single-cycle pulse
- `dbg_bp`  in  1  breakpoint/exception hit, single-cycle pulse

## Operation
- FSM: IDLE, ACCESS, RESP. Reset state is IDLE.
- `host_gnt` = (state == IDLE), combinational. A command is accepted when `host_req & host_gnt`.
- Read/write, allowed when the bank is 0 or `halted` = 1:
  - Register `dbg_addr`, `dbg_we` (= cmd[0]) and `dbg_dati`, set `dbg_strb`, go to ACCESS.
  - In ACCESS, hold `dbg_strb` and the address/data until `dbg_ack`.
  - On `dbg_ack`: capture `dbg_dato` for reads (0 for writes), drop `dbg_strb`, set err = 0, go to RESP.
- Read/write to a non-zero bank while not halted: no strobe; go to RESP with err = 1, data = 0.
- Halt: set `halted`, clear `host_bp_halt`; go to RESP with err = 0. Halt while already halted: no state change, err = 0.
- Resume: clear `halted` on acceptance; go to RESP with err = 0. Resume while running: no-op, err = 0.
- Breakpoint: a `dbg_bp` pulse while not halted sets `halted` and `host_bp_halt` on the next edge, in any FSM state. An in-flight access continues unaffected.
- Simultaneous `dbg_bp` and accepted resume: resume wins, `halted` = 0.
- RESP: hold `host_rsp_vld` = 1 with data/err stable until `host_rsp_rdy`, then go to IDLE. This guarantees `dbg_strb` is low for ≥ 2 cycles between accesses.
- `dbg_stall` = `host_halted` = `halted` register.
- Reset mid-access: all outputs return to reset values immediately; `dbg_strb` drops asynchronously; the CPU is released.
- Reset values: `host_gnt` 1 (IDLE), `host_rsp_vld` 0, `host_rsp_data` 0, `host_rsp_err` 0, `host_halted` 0, `host_bp_halt` 0, `dbg_stall` 0, `dbg_strb` 0, `dbg_we` 0, `dbg_addr` 0, `dbg_dati` 0.

## Timing
- Command accepted at edge N → `dbg_strb` = 1 from N+1.
- `dbg_ack` sampled at edge M → at M+1: `dbg_strb` = 0 and `host_rsp_vld` = 1. Minimum access (strobe-to-response) is 4 cycles given the debug unit's 3-cycle ack.
- Halt/resume/reject accepted at N → `host_rsp_vld` = 1 and `halted` updated at N+1.
- `dbg_bp` at edge N → `dbg_stall` = 1 at N+1.
- `dbg_we`, `dbg_addr` and `dbg_dati` are stable for the whole strobe.

## Configuration
- `RISCV_DBG_TIMEOUT_EN` defined: ACCESS runs a `$clog2(TIMEOUT+1)`-bit counter, cleared on entry. If the count reaches `TIMEOUT` without `dbg_ack`: drop `dbg_strb`, respond err = 1, data = 0. A `dbg_ack` in the same cycle as expiry wins (normal response).
- Not defined: no counter; ACCESS waits for `dbg_ack` indefinitely; `host_rsp_err` is set only by rejection.

## Test plan
- Halt, then read `0x1005` with `dbg_ack` 3 cycles after strobe and `dbg_dato` = `0xDEADBEEF` → strobe high 3 cycles, `rsp_vld` next cycle, data `0xDEADBEEF`, err 0.
- Read `0x1005` while running → no `dbg_strb`, rsp err 1, data 0; write `0x0000` with `0x3` while running → strobe, `dbg_we` = 1, `dbg_dati` = 3, err 0.
- `dbg_bp` pulse while running → `dbg_stall` = 1 and `host_bp_halt` = 1 next cycle; resume → both stall and `halted` drop one cycle after acceptance; `dbg_bp` + resume in the same cycle → `halted` 0.
- `TIMEOUT` = 8, `RISCV_DBG_TIMEOUT_EN` defined, no ack → strobe drops after 8 cycles, err 1; ack exactly on cycle 8 → err 0.
- Hold `host_rsp_rdy` = 0 for 5 cycles → rsp held stable, `host_gnt` = 0, no new strobe; assert `rstn` = 0 mid-ACCESS → `dbg_strb`/`dbg_stall` = 0 immediately.

Source files
------------

// File: rtl/riscv_dbg_ctrl.sv
// riscv_dbg_ctrl: host debug command to RISC-V debug unit strobe/ack bridge.
// Owns the CPU halt state, auto-halts on breakpoint, rejects banked accesses
// while the CPU runs. Optional ack timeout: define RISCV_DBG_TIMEOUT_EN.
module riscv_dbg_ctrl #(
    parameter int XLEN          = 32,
    parameter int DBG_ADDR_SIZE = 16,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     host_req,
    output logic                     host_gnt,
    input  logic [1:0]               host_cmd,
    input  logic [DBG_ADDR_SIZE-1:0] host_addr,
    input  logic [XLEN-1:0]          host_wdata,
    output logic                     host_rsp_vld,
    input  logic                     host_rsp_rdy,
    output logic [XLEN-1:0]          host_rsp_data,
    output logic                     host_rsp_err,
    output logic                     host_halted,
    output logic                     host_bp_halt,
    output logic                     dbg_stall,
    output logic                     dbg_strb,
    output logic                     dbg_we,
    output logic [DBG_ADDR_SIZE-1:0] dbg_addr,
    output logic [XLEN-1:0]          dbg_dati,
    input  logic [XLEN-1:0]          dbg_dato,
    input  logic                     dbg_ack,
    input  logic                     dbg_bp
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    localparam logic [1:0] CMD_HALT   = 2'b10;
    localparam logic [1:0] CMD_RESUME = 2'b11;

    // Parameter sanity: the timeout counter is sized for 1..65535.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("riscv_dbg_ctrl: TIMEOUT out of range");
    end

    state_e                   state_q;
    logic                     halted_q, bp_halt_q;
    logic                     strb_q, we_q;
    logic [DBG_ADDR_SIZE-1:0] addr_q;
    logic [XLEN-1:0]          dati_q, rsp_data_q;
    logic                     rsp_vld_q, rsp_err_q;

    logic accept, cmd_rw, bank_ok, halt_acc, resume_acc;

`ifdef RISCV_DBG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] cnt_q;
`endif

    // Command decode; bank 0 is always accessible, others only while halted.
    assign host_gnt   = (state_q == S_IDLE);
    assign accept     = host_req & host_gnt;
    assign cmd_rw     = ~host_cmd[1];
    assign bank_ok    = (host_addr[DBG_ADDR_SIZE-1:12] == '0) | halted_q;
    assign halt_acc   = accept & (host_cmd == CMD_HALT);
    assign resume_acc = accept & (host_cmd == CMD_RESUME);

    assign host_rsp_vld  = rsp_vld_q;
    assign host_rsp_data = rsp_data_q;
    assign host_rsp_err  = rsp_err_q;
    assign host_halted   = halted_q;
    assign host_bp_halt  = bp_halt_q;
    assign dbg_stall     = halted_q;
    assign dbg_strb      = strb_q;
    assign dbg_we        = we_q;
    assign dbg_addr      = addr_q;
    assign dbg_dati      = dati_q;

    // Halt state tracking and the IDLE/ACCESS/RESP access sequencer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            halted_q   <= 1'b0;
            bp_halt_q  <= 1'b0;
            strb_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dati_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef RISCV_DBG_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            // Resume beats a coincident breakpoint; an explicit halt clears
            // the breakpoint flag only when it actually halts a running CPU.
            if (resume_acc) begin
                halted_q <= 1'b0;
            end else if (halt_acc) begin
                if (!halted_q) begin
                    halted_q  <= 1'b1;
                    bp_halt_q <= 1'b0;
                end
            end else if (dbg_bp && !halted_q) begin
                halted_q  <= 1'b1;
                bp_halt_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd_rw && bank_ok) begin
                            addr_q  <= host_addr;
                            we_q    <= host_cmd[0];
                            dati_q  <= host_wdata;
                            strb_q  <= 1'b1;
                            state_q <= S_ACCESS;
`ifdef RISCV_DBG_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end else begin
                            // Halt/resume complete at once; rejected access errors.
                            rsp_vld_q  <= 1'b1;
                            rsp_data_q <= '0;
                            rsp_err_q  <= cmd_rw;
                            state_q    <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dbg_ack) begin
                        strb_q     <= 1'b0;
                        rsp_vld_q  <= 1'b1;
                        rsp_data_q <= we_q ? '0 : dbg_dato;
                        rsp_err_q  <= 1'b0;
                        state_q    <= S_RESP;
                    end
`ifdef RISCV_DBG_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        // Strobe has been high TIMEOUT cycles with no ack.
                        strb_q     <= 1'b0;
                        rsp_vld_q  <= 1'b1;
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (host_rsp_rdy) begin
                        rsp_vld_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dbg_ctrl.sv
// Bench for riscv_dbg_ctrl: directed test-plan steps followed by random
// command traffic, checked against a halt-state / response model.
module tb_riscv_dbg_ctrl;

    localparam int XLEN = 32;
    localparam int AW   = 16;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            host_req, host_gnt;
    logic [1:0]      host_cmd;
    logic [AW-1:0]   host_addr;
    logic [XLEN-1:0] host_wdata;
    logic            host_rsp_vld, host_rsp_rdy;
    logic [XLEN-1:0] host_rsp_data;
    logic            host_rsp_err, host_halted, host_bp_halt;
    logic            dbg_stall, dbg_strb, dbg_we;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_dati, dbg_dato;
    logic            dbg_ack, dbg_bp;

    int checks = 0;
    int errors = 0;

    // Model of the architectural halt state.
    logic m_halted = 1'b0;
    logic m_bp     = 1'b0;

    riscv_dbg_ctrl #(.XLEN(XLEN), .DBG_ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .host_req(host_req), .host_gnt(host_gnt), .host_cmd(host_cmd),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rsp_vld(host_rsp_vld), .host_rsp_rdy(host_rsp_rdy),
        .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
        .host_halted(host_halted), .host_bp_halt(host_bp_halt),
        .dbg_stall(dbg_stall), .dbg_strb(dbg_strb), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_dati(dbg_dati), .dbg_dato(dbg_dato),
        .dbg_ack(dbg_ack), .dbg_bp(dbg_bp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_halt(input string tag);
        chk({tag, "_halted"}, host_halted, m_halted);
        chk({tag, "_stall"},  dbg_stall,   m_halted);
        chk({tag, "_bphalt"}, host_bp_halt, m_bp);
    endtask

    // One host transaction. d = strobe cycles until ack (0 = never ack),
    // bp_cmd = breakpoint in the accept cycle, bp_at = breakpoint in strobe cycle.
    task automatic do_cmd(input logic [1:0] cmd, input logic [AW-1:0] addr,
                          input logic [XLEN-1:0] wd, input int d,
                          input logic [XLEN-1:0] dato, input int rdy_dly,
                          input bit bp_cmd, input int bp_at);
        logic rw, allowed, exp_err;
        logic [XLEN-1:0] exp_data;
        rw      = !cmd[1];
        allowed = (addr[AW-1:12] == 0) || m_halted;
        chk("gnt_idle", host_gnt, 1'b1);
        host_req = 1'b1; host_cmd = cmd; host_addr = addr; host_wdata = wd;
        dbg_bp = bp_cmd;
        step();
        host_req = 1'b0; dbg_bp = 1'b0;
        if (cmd == 2'b11) m_halted = 1'b0;
        else if (cmd == 2'b10) begin
            if (!m_halted) begin m_halted = 1'b1; m_bp = 1'b0; end
        end else if (bp_cmd && !m_halted) begin
            m_halted = 1'b1; m_bp = 1'b1;
        end
        chk("halted_acc", host_halted, m_halted);
        if (rw && allowed) begin
            chk("strb_rise", dbg_strb, 1'b1);
            chk("we",   dbg_we,   cmd[0]);
            chk("addr", dbg_addr, addr);
            chk("dati", dbg_dati, wd);
            for (int i = 1; i <= 64; i++) begin
                if (d == i) begin dbg_ack = 1'b1; dbg_dato = dato; end
                else dbg_dato = $urandom;
                if (bp_at == i) dbg_bp = 1'b1;
                step();
                dbg_ack = 1'b0; dbg_bp = 1'b0;
                if (bp_at == i && !m_halted) begin m_halted = 1'b1; m_bp = 1'b1; end
                if (d == i || (d == 0 && i == TO)) break;
                chk("strb_hold", dbg_strb, 1'b1);
                chk("addr_hold", dbg_addr, addr);
                chk("dati_hold", dbg_dati, wd);
            end
            exp_err  = (d == 0);
            exp_data = (d == 0 || cmd[0]) ? '0 : dato;
        end else begin
            chk("no_strb", dbg_strb, 1'b0);
            exp_err  = rw;
            exp_data = '0;
        end
        chk("strb_low", dbg_strb, 1'b0);
        chk("rsp_vld",  host_rsp_vld, 1'b1);
        chk("rsp_data", host_rsp_data, exp_data);
        chk("rsp_err",  host_rsp_err, exp_err);
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            chk("hold_vld",  host_rsp_vld, 1'b1);
            chk("hold_data", host_rsp_data, exp_data);
            chk("hold_err",  host_rsp_err, exp_err);
            chk("hold_gnt",  host_gnt, 1'b0);
            chk("hold_strb", dbg_strb, 1'b0);
        end
        host_rsp_rdy = 1'b1;
        step();
        host_rsp_rdy = 1'b0;
        chk("rsp_done", host_rsp_vld, 1'b0);
        chk("gnt_back", host_gnt, 1'b1);
        chk_halt("end");
    endtask

    task automatic bp_pulse();
        dbg_bp = 1'b1;
        step();
        dbg_bp = 1'b0;
        if (!m_halted) begin m_halted = 1'b1; m_bp = 1'b1; end
        chk_halt("bp");
    endtask

    initial begin
        logic [1:0]    c;
        logic [AW-1:0] a;
        int            r;
        rstn = 1'b0; host_req = 1'b0; host_cmd = '0; host_addr = '0;
        host_wdata = '0; host_rsp_rdy = 1'b0; dbg_dato = '0;
        dbg_ack = 1'b0; dbg_bp = 1'b0;
        #12;
        // reset values
        chk("rst_gnt", host_gnt, 1'b1);
        chk("rst_vld", host_rsp_vld, 1'b0);
        chk("rst_data", host_rsp_data, '0);
        chk("rst_err", host_rsp_err, 1'b0);
        chk_halt("rst");
        chk("rst_strb", dbg_strb, 1'b0);
        chk("rst_we", dbg_we, 1'b0);
        chk("rst_addr", dbg_addr, '0);
        chk("rst_dati", dbg_dati, '0);
        rstn = 1'b1;
        step();

        // halt, then banked read with ack on the third strobe cycle
        do_cmd(2'b10, '0, '0, 1, '0, 0, 1'b0, 0);
        do_cmd(2'b00, 16'h1005, '0, 3, 32'hDEADBEEF, 0, 1'b0, 0);
        // resume, then banked read rejected, bank-0 write allowed
        do_cmd(2'b11, '0, '0, 1, '0, 0, 1'b0, 0);
        do_cmd(2'b00, 16'h1005, '0, 3, 32'h1234, 0, 1'b0, 0);
        do_cmd(2'b01, 16'h0000, 32'h3, 3, '0, 0, 1'b0, 0);
        // breakpoint while running, then resume, then breakpoint + resume
        bp_pulse();
        do_cmd(2'b11, '0, '0, 1, '0, 0, 1'b0, 0);
        bp_pulse();
        do_cmd(2'b11, '0, '0, 1, '0, 0, 1'b1, 0);
        // halt while halted keeps breakpoint flag; slow response consumer
        bp_pulse();
        do_cmd(2'b10, '0, '0, 1, '0, 0, 1'b0, 0);
        do_cmd(2'b00, 16'h2abc, '0, 2, 32'hCAFEF00D, 5, 1'b0, 0);
        do_cmd(2'b11, '0, '0, 1, '0, 0, 1'b0, 0);
        // breakpoint during an in-flight access
        do_cmd(2'b00, 16'h0040, '0, 4, 32'h55AA, 0, 1'b0, 2);
        do_cmd(2'b11, '0, '0, 1, '0, 0, 1'b0, 0);
`ifdef RISCV_DBG_TIMEOUT_EN
        do_cmd(2'b00, 16'h0010, '0, 0, '0, 0, 1'b0, 0);
        do_cmd(2'b00, 16'h0010, '0, TO, 32'h77, 0, 1'b0, 0);
`endif

        // random traffic
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            c = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : {1'b0, 1'($urandom_range(0, 1))};
            a = AW'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) a[AW-1:12] = 4'($urandom_range(1, 15));
            do_cmd(c, a, $urandom, $urandom_range(1, TO), $urandom,
                   $urandom_range(0, 3),
                   (c != 2'b10) && ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) bp_pulse();
        end

        // asynchronous reset mid-access while halted
        do_cmd(2'b10, '0, '0, 1, '0, 0, 1'b0, 0);
        host_req = 1'b1; host_cmd = 2'b00; host_addr = 16'h3000;
        step();
        host_req = 1'b0;
        chk("pre_rst_strb", dbg_strb, 1'b1);
        #2 rstn = 1'b0;
        #1;
        m_halted = 1'b0; m_bp = 1'b0;
        chk("arst_strb", dbg_strb, 1'b0);
        chk("arst_vld", host_rsp_vld, 1'b0);
        chk("arst_gnt", host_gnt, 1'b1);
        chk_halt("arst");
        step();
        rstn = 1'b1;
        step();
        do_cmd(2'b01, 16'h0008, 32'hA5A5, 3, '0, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
